// File: rtl/ps2_keypad_if.sv
// ps2_keypad_if
//   Groups the PS/2 line inputs and the decoded key-event outputs of
//   ps2_keypad into one bundle.
//   slave  : the keypad front end (samples the lines, drives the events)
//   master : whatever drives the PS/2 lines and consumes the events
// Signals:
//   ps2_clk, ps2_data      raw PS/2 lines, asynchronous to the system clock
//   operation[5:0]         one-cycle pulse per new key press
//   held[5:0]              level per key, make to break
//   scan_code[7:0]         last correctly received byte
//   code_valid, frame_err  one-cycle status pulses
interface ps2_keypad_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [5:0] operation;
    logic [5:0] held;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  operation, held, scan_code, code_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output operation, held, scan_code, code_valid, frame_err
    );
endinterface

// File: rtl/ps2_keypad.sv
// ps2_keypad
//   PS/2 keyboard front end: synchronises and filters the raw PS/2 lines,
//   receives 11-bit device-to-host frames, tracks the E0/F0 prefixes and
//   maps six keys onto operation/held vectors.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   ps2_keypad_if.slave (lines in, decoded events out)
// Key bit order: [0] up, [1] down, [2] left, [3] right, [4] enter, [5] esc.
module ps2_keypad #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic          clk,
    input  logic          rst,
    ps2_keypad_if.slave   bus
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Key lookup: returns {hit, index[2:0]}.
    function automatic logic [3:0] key_lookup(input logic [7:0] code, input logic ext);
        logic [3:0] res;
        res = 4'b0000;
        if (ext) begin
            case (code)
                8'h75:   res = 4'b1000;
                8'h72:   res = 4'b1001;
                8'h6B:   res = 4'b1010;
                8'h74:   res = 4'b1011;
                8'h5A:   res = 4'b1100;
                default: res = 4'b0000;
            endcase
        end else begin
            case (code)
                8'h1D:   res = 4'b1000;
                8'h1B:   res = 4'b1001;
                8'h1C:   res = 4'b1010;
                8'h23:   res = 4'b1011;
                8'h5A:   res = 4'b1100;
                8'h76:   res = 4'b1101;
                default: res = 4'b0000;
            endcase
        end
        return res;
    endfunction

    logic [1:0]    r_sync_clk;
    logic [1:0]    r_sync_data;
    logic          r_filt_clk;
    logic          r_filt_data;
    logic [FW-1:0] r_cnt_clk;
    logic [FW-1:0] r_cnt_data;
    logic          r_filt_clk_d;

    logic [1:0]    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_scan_code;
    logic          r_code_valid;
    logic          r_frame_err;

    logic          r_ext;
    logic          r_brk;
    logic [5:0]    r_held;
    logic [5:0]    r_operation;

    logic          w_strobe;
    logic [3:0]    w_lookup;
    logic [2:0]    w_key_idx;

    // Two-flop synchronisers; lines idle high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_clk  <= 2'b11;
            r_sync_data <= 2'b11;
        end else begin
            r_sync_clk  <= {r_sync_clk[0], bus.ps2_clk};
            r_sync_data <= {r_sync_data[0], bus.ps2_data};
        end
    end

    // Clock-line filter: flips after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt_clk <= 1'b1;
            r_cnt_clk  <= FW'(0);
        end else if (r_sync_clk[1] == r_filt_clk) begin
            r_cnt_clk  <= FW'(0);
        end else if (r_cnt_clk == FILT_LAST) begin
            r_filt_clk <= r_sync_clk[1];
            r_cnt_clk  <= FW'(0);
        end else begin
            r_cnt_clk  <= r_cnt_clk + FW'(1);
        end
    end

    // Data-line filter, same rule as the clock line so both see equal latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt_data <= 1'b1;
            r_cnt_data  <= FW'(0);
        end else if (r_sync_data[1] == r_filt_data) begin
            r_cnt_data  <= FW'(0);
        end else if (r_cnt_data == FILT_LAST) begin
            r_filt_data <= r_sync_data[1];
            r_cnt_data  <= FW'(0);
        end else begin
            r_cnt_data  <= r_cnt_data + FW'(1);
        end
    end

    // Delayed filtered clock for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt_clk_d <= 1'b1;
        end else begin
            r_filt_clk_d <= r_filt_clk;
        end
    end

    assign w_strobe = r_filt_clk_d & ~r_filt_clk;

    // Frame receiver; a strobe takes priority over a coincident timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_parity     <= 1'b0;
            r_to_cnt     <= TW'(0);
            r_scan_code  <= 8'h00;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_strobe) begin
                r_to_cnt <= TW'(0);
                case (r_state)
                    S_IDLE: begin
                        if (!r_filt_data) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            r_state   <= S_IDLE;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {r_filt_data, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_PARITY: begin
                        r_parity <= r_filt_data;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        if (r_filt_data && odd_parity_ok(r_shift, r_parity)) begin
                            r_scan_code  <= r_shift;
                            r_code_valid <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == TO_LAST) begin
                    r_frame_err <= 1'b1;
                    r_state     <= S_IDLE;
                    r_to_cnt    <= TW'(0);
                    r_shift     <= 8'h00;
                    r_bit_cnt   <= 3'd0;
                end else begin
                    r_to_cnt    <= r_to_cnt + TW'(1);
                end
            end else begin
                r_to_cnt <= TW'(0);
            end
        end
    end

    assign w_lookup  = key_lookup(r_scan_code, r_ext);
    assign w_key_idx = w_lookup[2:0];

    // Prefix tracking and key decode, one cycle behind code_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_held      <= 6'b000000;
            r_operation <= 6'b000000;
        end else begin
            r_operation <= 6'b000000;
            if (r_frame_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (r_code_valid) begin
                if (r_scan_code == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_scan_code == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (w_lookup[3]) begin
                        if (!r_brk) begin
                            r_held[w_key_idx] <= 1'b1;
                            // Typematic repeats of a held key do not pulse.
                            if (!r_held[w_key_idx]) begin
                                r_operation[w_key_idx] <= 1'b1;
                            end else begin
                                r_operation[w_key_idx] <= 1'b0;
                            end
                        end else begin
                            r_held[w_key_idx] <= 1'b0;
                        end
                    end else begin
                        r_held <= r_held;
                    end
                end
            end else begin
                r_ext <= r_ext;
                r_brk <= r_brk;
            end
        end
    end

    assign bus.operation  = r_operation;
    assign bus.held       = r_held;
    assign bus.scan_code  = r_scan_code;
    assign bus.code_valid = r_code_valid;
    assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_keypad.sv
module tb_ps2_keypad;

    localparam int FILT = 8;
    localparam int TO   = 300;
    localparam int H    = 20;   // PS/2 half bit period in clk cycles

    logic clk;
    logic rst;
    ps2_keypad_if ifc ();

    ps2_keypad #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       bad_stop;
        logic       exp_valid;
        logic       exp_err;
        logic [7:0] exp_scan;
        logic [5:0] exp_op;
        logic [5:0] exp_held;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    int n_vec = 0;
    int n_bad = 0;

    // Event monitor: running totals sampled on the falling edge.
    int         n_cv = 0, n_fe = 0, n_op = 0, n_lat = 0, n_multi = 0;
    logic [5:0] op_last = 6'b000000;
    logic       prev_cv = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_cv = 1'b0;
        end else begin
            if (ifc.code_valid) n_cv++;
            if (ifc.frame_err)  n_fe++;
            if (ifc.operation != 6'b000000) begin
                n_op++;
                op_last = ifc.operation;
                if (!prev_cv) n_lat++;
                if (!$onehot0(ifc.operation)) n_multi++;
            end
            prev_cv = ifc.code_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive nbits frame bits LSB-first, each bit set while the PS/2 clock is high.
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ifc.ps2_data = bits[i];
            step(H);
            ifc.ps2_clk = 1'b0;
            step(H);
            ifc.ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad_par,
                                             input logic bad_stop);
        logic p;
        p = (~^code) ^ bad_par;
        return {~bad_stop, p, code, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
        send_bits(mk_frame(code, bad_par, bad_stop), 11);
        ifc.ps2_data = 1'b1;
        step(2 * H);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " op"},    {26'd0, ifc.operation}, 32'd0);
        check({tag, " held"},  {26'd0, ifc.held},      32'd0);
        check({tag, " scan"},  {24'd0, ifc.scan_code}, 32'd0);
        check({tag, " cv"},    {31'd0, ifc.code_valid}, 32'd0);
        check({tag, " ferr"},  {31'd0, ifc.frame_err},  32'd0);
    endtask

    // Send one frame and compare the observed events with the record.
    task automatic apply(input vec_t v, input string tag);
        int cv0, fe0, op0;
        cv0 = n_cv; fe0 = n_fe; op0 = n_op;
        send_frame(v.code, v.bad_par, v.bad_stop);
        check({tag, " code_valid"}, n_cv - cv0, {31'd0, v.exp_valid});
        check({tag, " frame_err"},  n_fe - fe0, {31'd0, v.exp_err});
        check({tag, " op_pulses"},  n_op - op0, (v.exp_op != 6'b000000) ? 32'd1 : 32'd0);
        if (v.exp_op != 6'b000000) begin
            check({tag, " operation"}, {26'd0, op_last}, {26'd0, v.exp_op});
        end
        check({tag, " held"},      {26'd0, ifc.held},      {26'd0, v.exp_held});
        check({tag, " scan_code"}, {24'd0, ifc.scan_code}, {24'd0, v.exp_scan});
    endtask

    initial begin
        int cv0, fe0, op0;
        vec_t v;

        //              code   bpar  bstop  val   err   scan   op         held
        tbl[0]  = '{8'h1D, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1D, 6'b000001, 6'b000001};
        tbl[1]  = '{8'h1D, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1D, 6'b000000, 6'b000001};
        tbl[2]  = '{8'h1D, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1D, 6'b000000, 6'b000001};
        tbl[3]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 6'b000000, 6'b000001};
        tbl[4]  = '{8'h1D, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1D, 6'b000000, 6'b000000};
        tbl[5]  = '{8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE0, 6'b000000, 6'b000000};
        tbl[6]  = '{8'h72, 1'b0, 1'b0, 1'b1, 1'b0, 8'h72, 6'b000010, 6'b000010};
        tbl[7]  = '{8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE0, 6'b000000, 6'b000010};
        tbl[8]  = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 6'b000000, 6'b000010};
        tbl[9]  = '{8'h72, 1'b0, 1'b0, 1'b1, 1'b0, 8'h72, 6'b000000, 6'b000000};
        tbl[10] = '{8'h72, 1'b0, 1'b0, 1'b1, 1'b0, 8'h72, 6'b000000, 6'b000000};
        tbl[11] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 6'b000100, 6'b000100};
        tbl[12] = '{8'h1D, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C, 6'b000000, 6'b000100};
        tbl[13] = '{8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE0, 6'b000000, 6'b000100};
        tbl[14] = '{8'h74, 1'b0, 1'b0, 1'b1, 1'b0, 8'h74, 6'b001000, 6'b001100};
        tbl[15] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 6'b010000, 6'b011100};
        tbl[16] = '{8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE0, 6'b000000, 6'b011100};
        tbl[17] = '{8'h1D, 1'b1, 1'b0, 1'b0, 1'b1, 8'hE0, 6'b000000, 6'b011100};
        tbl[18] = '{8'h75, 1'b0, 1'b0, 1'b1, 1'b0, 8'h75, 6'b000000, 6'b011100};
        tbl[19] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 6'b000000, 6'b011100};
        tbl[20] = '{8'h23, 1'b0, 1'b0, 1'b1, 1'b0, 8'h23, 6'b000000, 6'b010100};
        tbl[21] = '{8'h1D, 1'b0, 1'b1, 1'b0, 1'b1, 8'h23, 6'b000000, 6'b010100};
        tbl[22] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 6'b000000, 6'b010100};
        tbl[23] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 6'b000000, 6'b010100};
        tbl[24] = '{8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 6'b000000, 6'b000100};
        tbl[25] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 6'b000000, 6'b000100};
        tbl[26] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1C, 6'b000000, 6'b000000};

        ifc.ps2_clk  = 1'b1;
        ifc.ps2_data = 1'b1;
        rst = 1'b0;
        step(3);
        check_outputs_zero("reset");
        rst = 1'b1;
        step(20);
        check_outputs_zero("post-reset");
        check("post-reset state", {30'd0, dut.r_state}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], $sformatf("vec%0d(%02h)", i, tbl[i].code));
        end

        // Timeout after four data bits, then a valid Esc.
        cv0 = n_cv; fe0 = n_fe;
        send_bits(mk_frame(8'h76, 1'b0, 1'b0), 5);
        ifc.ps2_data = 1'b1;
        step(TO - 100);
        check("timeout early", n_fe - fe0, 32'd0);
        check("timeout state busy", {31'd0, dut.r_state != 2'd0}, 32'd1);
        step(150);
        check("timeout frame_err", n_fe - fe0, 32'd1);
        check("timeout code_valid", n_cv - cv0, 32'd0);
        check("timeout state", {30'd0, dut.r_state}, 32'd0);
        v = '{8'h76, 1'b0, 1'b0, 1'b1, 1'b0, 8'h76, 6'b100000, 6'b100000};
        apply(v, "after-timeout(76)");

        // Reset mid-frame.
        send_bits(mk_frame(8'h1D, 1'b0, 1'b0), 6);
        rst = 1'b0;
        #1;
        check_outputs_zero("midframe-reset");
        check("midframe-reset state", {30'd0, dut.r_state}, 32'd0);
        ifc.ps2_data = 1'b1;
        step(5);
        rst = 1'b1;
        step(40);
        v = '{8'h1D, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1D, 6'b000001, 6'b000001};
        apply(v, "after-reset(1D)");

        // Short clock glitch with data held low: must not start a frame.
        cv0 = n_cv; fe0 = n_fe; op0 = n_op;
        ifc.ps2_data = 1'b0;
        step(30);
        ifc.ps2_clk = 1'b0;
        step(FILT - 1);
        ifc.ps2_clk = 1'b1;
        step(30);
        check("glitch state", {30'd0, dut.r_state}, 32'd0);
        ifc.ps2_data = 1'b1;
        step(TO + 50);
        check("glitch code_valid", n_cv - cv0, 32'd0);
        check("glitch frame_err", n_fe - fe0, 32'd0);
        check("glitch op", n_op - op0, 32'd0);
        check("glitch held", {26'd0, ifc.held}, 32'h01);

        check("op latency", n_lat, 32'd0);
        check("op onehot", n_multi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
